// File: rtl/lcg_stream_checker_if.sv
// Valid/ready word stream carrying LCG stimulus from the sender to the checker.
interface lcg_stream_checker_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcg_stream_checker.sv
// Regenerates the seeded LCG frame sequence and checks an incoming stream against it.
// Optional build macro LCG_CHK_RESYNC_EN: re-lock the LCG to the received word on full-width mismatches.
module lcg_stream_checker #(
  parameter logic [31:0] MULT        = 32'h41C64E6D,
  parameter logic [31:0] INC         = 32'h0000_3039,
  parameter int          FRAME_WORDS = 9,
  parameter int          LAST_W      = 15,
  parameter int          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_valid_i,
  input  logic [31:0]          seed_i,
  lcg_stream_checker_if.slave  in_if,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     match_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 first_err_vld_o,
  output logic [CNT_W-1:0]     first_err_idx_o,
  output logic [31:0]          first_err_exp_o,
  output logic [31:0]          first_err_got_o,
  output logic [3:0]           word_idx_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_WORDS - 1);
  localparam logic [31:0] LAST_MASK = 32'hFFFF_FFFF >> (32 - LAST_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      lcg_q, lcg_d;
  logic [3:0]       widx_q, widx_d;
  logic [CNT_W-1:0] gidx_q, gidx_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [CNT_W-1:0] fei_q, fei_d;
  logic [31:0]      fee_q, fee_d;
  logic [31:0]      feg_q, feg_d;

  logic [31:0] nxt_s;
  logic [31:0] mask_s;
  logic        last_s;
  logic        equal_s;
  logic        xfer_s;

  assign nxt_s   = lcg_q * MULT + INC;
  assign last_s  = (widx_q == LAST_IDX);
  assign mask_s  = last_s ? LAST_MASK : 32'hFFFF_FFFF;
  assign equal_s = ((in_if.in_data ^ nxt_s) & mask_s) == 32'h0000_0000;
  assign xfer_s  = in_if.in_valid && (state_q == S_RUN);

  // Next-state logic: seeding, word compare, counters and first-error capture.
  always_comb begin
    state_d = state_q;
    lcg_d   = lcg_q;
    widx_d  = widx_q;
    gidx_d  = gidx_q;
    match_d = match_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    fee_d   = fee_q;
    feg_d   = feg_q;
    if (seed_valid_i) begin
      // Seeding wins over any transfer presented in the same cycle.
      state_d = S_RUN;
      lcg_d   = seed_i;
      widx_d  = 4'd0;
      gidx_d  = '0;
      match_d = '0;
      err_d   = '0;
      fev_d   = 1'b0;
      fei_d   = '0;
      fee_d   = 32'h0000_0000;
      feg_d   = 32'h0000_0000;
    end else if (xfer_s) begin
      gidx_d = sat_inc(gidx_q);
      widx_d = last_s ? 4'd0 : widx_q + 4'd1;
      if (equal_s) begin
        match_d = sat_inc(match_q);
      end else begin
        err_d = sat_inc(err_q);
        if (!fev_q) begin
          fev_d = 1'b1;
          fei_d = gidx_q;
          fee_d = nxt_s & mask_s;
          feg_d = in_if.in_data & mask_s;
        end else begin
          fev_d = fev_q;
        end
      end
`ifdef LCG_CHK_RESYNC_EN
      if (!equal_s && !last_s) begin
        lcg_d = in_if.in_data;
      end else begin
        lcg_d = nxt_s;
      end
`else
      lcg_d = nxt_s;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lcg_q   <= 32'h0000_0000;
      widx_q  <= 4'd0;
      gidx_q  <= '0;
      match_q <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      fee_q   <= 32'h0000_0000;
      feg_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      lcg_q   <= lcg_d;
      widx_q  <= widx_d;
      gidx_q  <= gidx_d;
      match_q <= match_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      fee_q   <= fee_d;
      feg_q   <= feg_d;
    end
  end

  assign in_if.in_ready  = (state_q == S_RUN);
  assign busy_o          = (state_q == S_RUN);
  assign match_cnt_o     = match_q;
  assign err_cnt_o       = err_q;
  assign first_err_vld_o = fev_q;
  assign first_err_idx_o = fei_q;
  assign first_err_exp_o = fee_q;
  assign first_err_got_o = feg_q;
  assign word_idx_o      = widx_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Randomized self-checking bench for lcg_stream_checker against a word-level reference model.
module tb_lcg_stream_checker;
  localparam logic [31:0] MULT = 32'h41C64E6D;
  localparam logic [31:0] INC  = 32'h0000_3039;
  localparam int FW = 9;
  localparam int LW = 15;
  localparam int CW = 16;
  localparam longint SAT = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, seed_valid, seed_valid2;
  logic [31:0] seed, seed2;
  logic            busy, fev, busy2, fev2;
  logic [CW-1:0]   match_cnt, err_cnt, fei;
  logic [31:0]     fee, feg, fee2, feg2;
  logic [3:0]      widx, widx2;
  logic [3:0]      match2, err2, fei2;

  lcg_stream_checker_if ifs ();
  lcg_stream_checker_if ifs2 ();

  lcg_stream_checker dut (
    .clk(clk), .rst(rst), .seed_valid_i(seed_valid), .seed_i(seed), .in_if(ifs),
    .busy_o(busy), .match_cnt_o(match_cnt), .err_cnt_o(err_cnt),
    .first_err_vld_o(fev), .first_err_idx_o(fei), .first_err_exp_o(fee),
    .first_err_got_o(feg), .word_idx_o(widx));

  lcg_stream_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .seed_valid_i(seed_valid2), .seed_i(seed2), .in_if(ifs2),
    .busy_o(busy2), .match_cnt_o(match2), .err_cnt_o(err2),
    .first_err_vld_o(fev2), .first_err_idx_o(fei2), .first_err_exp_o(fee2),
    .first_err_got_o(feg2), .word_idx_o(widx2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the checker's observable state, tracked word by word.
  bit          m_run;
  logic [31:0] m_lcg, m_fee, m_feg;
  int          m_widx;
  longint      m_gidx, m_match, m_err, m_fei;
  bit          m_fev;

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    logic [63:0] p;
    p = {32'h0, s} * {32'h0, MULT} + {32'h0, INC};
    return p[31:0];
  endfunction

  function automatic longint sat(input longint v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_apply(input bit r, input bit sv, input logic [31:0] sd,
                             input bit v, input logic [31:0] d);
    logic [31:0] exp, mask;
    bit last, eq;
    if (r) begin
      m_run = 0; m_lcg = 0; m_widx = 0; m_gidx = 0; m_match = 0; m_err = 0;
      m_fev = 0; m_fei = 0; m_fee = 0; m_feg = 0;
    end else if (sv) begin
      m_run = 1; m_lcg = sd; m_widx = 0; m_gidx = 0; m_match = 0; m_err = 0;
      m_fev = 0; m_fei = 0; m_fee = 0; m_feg = 0;
    end else if (m_run && v) begin
      exp  = lcg_next(m_lcg);
      last = (m_widx == FW - 1);
      mask = last ? 32'((longint'(1) << LW) - 1) : 32'hFFFF_FFFF;
      eq   = ((d & mask) == (exp & mask));
      if (eq) m_match = sat(m_match + 1);
      else begin
        m_err = sat(m_err + 1);
        if (!m_fev) begin
          m_fev = 1; m_fei = m_gidx; m_fee = exp & mask; m_feg = d & mask;
        end
      end
      m_gidx = sat(m_gidx + 1);
`ifdef LCG_CHK_RESYNC_EN
      m_lcg = (!eq && !last) ? d : exp;
`else
      m_lcg = exp;
`endif
      m_widx = (m_widx + 1) % FW;
    end
  endtask

  task automatic check_all();
    check_eq("in_ready", 64'(ifs.in_ready), 64'(m_run));
    check_eq("busy", 64'(busy), 64'(m_run));
    check_eq("match_cnt", 64'(match_cnt), 64'(m_match));
    check_eq("err_cnt", 64'(err_cnt), 64'(m_err));
    check_eq("first_err_vld", 64'(fev), 64'(m_fev));
    check_eq("first_err_idx", 64'(fei), 64'(m_fei));
    check_eq("first_err_exp", 64'(fee), 64'(m_fee));
    check_eq("first_err_got", 64'(feg), 64'(m_feg));
    check_eq("word_idx", 64'(widx), 64'(m_widx));
  endtask

  task automatic cyc(input bit r, input bit sv, input logic [31:0] sd,
                     input bit v, input logic [31:0] d);
    rst = r; seed_valid = sv; seed = sd; ifs.in_valid = v; ifs.in_data = d;
    model_apply(r, sv, sd, v, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] g, s, d, gw;
    int k, guard;
    rst = 1'b1; seed_valid = 1'b0; seed = 32'h0; ifs.in_valid = 1'b0; ifs.in_data = 32'h0;
    seed_valid2 = 1'b0; seed2 = 32'h0; ifs2.in_valid = 1'b0; ifs2.in_data = 32'h0;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h1234, 1, 32'h5);
    check_eq("rst_ready", 64'(ifs.in_ready), 64'd0);

    // Two golden words back to back from seed 0
    cyc(0, 1, 32'h0, 0, 0);
    check_eq("seed_ready", 64'(ifs.in_ready), 64'd1);
    cyc(0, 0, 0, 1, 32'h0000_3039);
    cyc(0, 0, 0, 1, 32'hD3DC_167E);
    check_eq("t1_match", 64'(match_cnt), 64'd2);
    check_eq("t1_err", 64'(err_cnt), 64'd0);
    check_eq("t1_widx", 64'(widx), 64'd2);

    // Full frame, last word has garbage upper bits
    cyc(0, 1, 32'h0, 0, 0);
    g = 32'h0;
    for (int i = 0; i < FW; i++) begin
      g = lcg_next(g);
      d = (i == FW - 1) ? {17'h1A5A5, g[14:0]} : g;
      cyc(0, 0, 0, 1, d);
    end
    check_eq("t2_match", 64'(match_cnt), 64'd9);
    check_eq("t2_widx", 64'(widx), 64'd0);

    // First-error capture
    cyc(0, 1, 32'h0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_3039);
    cyc(0, 0, 0, 1, 32'hD3DC_167F);
    check_eq("t3_err", 64'(err_cnt), 64'd1);
    check_eq("t3_idx", 64'(fei), 64'd1);
    check_eq("t3_exp", 64'(fee), 64'hD3DC_167E);
    check_eq("t3_got", 64'(feg), 64'hD3DC_167F);
`ifdef LCG_CHK_RESYNC_EN
    gw = lcg_next(32'hD3DC_167F);
`else
    gw = lcg_next(32'hD3DC_167E);
`endif
    cyc(0, 0, 0, 1, gw);
    check_eq("t3_match", 64'(match_cnt), 64'd2);

    // Random in_valid gaps over three golden frames
    s = $urandom;
    cyc(0, 1, s, 0, 0);
    g = s; k = 0; guard = 0;
    while (k < 3 * FW && guard < 500) begin
      guard++;
      if ($urandom_range(0, 1) == 1) begin
        g = lcg_next(g);
        cyc(0, 0, 0, 1, g);
        k++;
      end else begin
        cyc(0, 0, 0, 0, $urandom);
      end
    end
    check_eq("t4_done", 64'(k), 64'(3 * FW));
    check_eq("t4_match", 64'(match_cnt), 64'd27);
    check_eq("t4_err", 64'(err_cnt), 64'd0);

    // Reseed mid-frame together with a valid word
    s = $urandom;
    cyc(0, 1, s, 0, 0);
    g = s;
    for (int i = 0; i < 4; i++) begin
      g = lcg_next(g);
      cyc(0, 0, 0, 1, g);
    end
    s = $urandom;
    cyc(0, 1, s, 1, lcg_next(g));
    check_eq("t5_match", 64'(match_cnt), 64'd0);
    check_eq("t5_widx", 64'(widx), 64'd0);
    g = s;
    for (int i = 0; i < 3; i++) begin
      g = lcg_next(g);
      cyc(0, 0, 0, 1, g);
    end

    // Random traffic with corruption and occasional reseeds
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cyc(0, 1, $urandom, $urandom_range(0, 1), $urandom);
      end else begin
        d = lcg_next(m_lcg);
        if ($urandom_range(0, 4) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
        cyc(0, 0, 0, $urandom_range(0, 3) != 0, d);
      end
    end

    // Reset mid-frame, with seed_valid also high
    s = $urandom;
    cyc(0, 1, s, 0, 0);
    cyc(0, 0, 0, 1, lcg_next(s));
    cyc(1, 1, s, 1, 32'h0);
    check_eq("t6_ready", 64'(ifs.in_ready), 64'd0);
    check_eq("t6_match", 64'(match_cnt), 64'd0);
    cyc(0, 0, 0, 1, 32'h0);

    // Saturation with a 4-bit counter build
    check_eq("sat_idle_ready", 64'(ifs2.in_ready), 64'd0);
    seed_valid2 = 1'b1; seed2 = 32'h0;
    @(posedge clk); #1;
    seed_valid2 = 1'b0;
    g = 32'h0;
    for (int i = 0; i < 20; i++) begin
      g = lcg_next(g);
      ifs2.in_valid = 1'b1; ifs2.in_data = g;
      @(posedge clk); #1;
    end
    ifs2.in_valid = 1'b0;
    check_eq("sat_match", 64'(match2), 64'd15);
    check_eq("sat_err", 64'(err2), 64'd0);
    check_eq("sat_fev", 64'(fev2), 64'd0);
    check_eq("sat_widx", 64'(widx2), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcg_stream_checker.md
# lcg_stream_checker

Receive-side checker for the LCG stimulus stream that drives our fuzz benches. The benches generate stimulus as frames of nine 32-bit LCG words, and the last word of each frame is truncated to 15 bits. This block is seeded with the same seed, regenerates the expected sequence in hardware and compares it word by word against an incoming valid/ready stream. It sits at the far end of a stimulus link and reports match and error counts plus first-error diagnostics.

## Interface
Parameters:
- MULT, default 32'h41C64E6D: LCG multiplier.
- INC, default 32'h3039: LCG increment.
- FRAME_WORDS, default 9: words per frame, including the truncated last word.
- LAST_W, default 15: number of valid low bits in the last word of each frame.
- CNT_W, default 16: width of the match and error counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- seed_valid  in  1  load seed; accepted in any state.
- seed  in  32  initial LCG state.
- in_valid  in  1  incoming word valid.
- in_data  in  32  incoming word.
- in_ready  out  1  checker accepts a word this cycle.
- busy  out  1  checker is in the RUN state.
- match_cnt  out  CNT_W  number of words that compared equal; saturates at all-ones.
- err_cnt  out  CNT_W  number of words that mismatched; saturates at all-ones.
- first_err_vld  out  1  a first error has been captured.
- first_err_idx  out  CNT_W  global word index of the first error.
- first_err_exp  out  32  expected word at the first error.
- first_err_got  out  32  received word at the first error.
- word_idx  out  4  position of the next word within its frame, 0..FRAME_WORDS-1.

## Operation
States are IDLE and RUN.

Reset (rst=1 at a clock edge):
- State goes to IDLE.
- All outputs go to 0, and the internal LCG state goes to 0.

IDLE:
- in_ready=0, busy=0.
- seed_valid=1 loads the internal state with seed, clears all counters, first_err_* and word_idx, and moves to RUN.

RUN:
- in_ready=1, busy=1.
- The expected word is nxt = state*MULT+INC, truncated to 32 bits.
- On a transfer (in_valid&in_ready):
  - If word_idx<FRAME_WORDS-1, compare all 32 bits.
  - If word_idx==FRAME_WORDS-1, compare only bits [LAST_W-1:0]; the upper bits of in_data are ignored.
  - The internal state advances to nxt (the full 32 bits) regardless of the compare result.
  - word_idx increments and wraps from FRAME_WORDS-1 to 0.
  - Equal: match_cnt increments. Unequal: err_cnt increments.
  - On the first mismatch since the seed was loaded, capture first_err_idx (the count of words transferred before this one), first_err_exp (masked) and first_err_got (masked), and set first_err_vld. Later mismatches never overwrite this capture.
- seed_valid in RUN reseeds with the same clearing as in IDLE. A transfer in the same cycle is discarded, and seed_valid wins.
- Both counters saturate at 2^CNT_W-1. The global word index used for first_err_idx also saturates.
- No other transitions exist. Only rst returns the block to IDLE.

## Timing
- in_ready is a registered state decode. It asserts in the cycle after seed_valid is sampled.
- All status outputs are registered. They reflect a transfer at edge N from cycle N+1 onward, so compare latency is 1 cycle.
- Throughput is one word per cycle with no bubbles, including across frame boundaries.
- in_valid low stalls the block: the state, word_idx and counters all hold.
- If rst and seed_valid are high together, rst wins and the state is IDLE.
- Reset asserted mid-frame discards the partial frame with no residual state.

## Configuration
- LCG_CHK_RESYNC_EN:
  - Defined: on a full-width (non-last-word) mismatch, the internal state is loaded with the received in_data instead of nxt. The checker then re-locks to the stream after a dropped or inserted word, and the err_cnt and first_err capture behaviour is unchanged. Truncated last-word mismatches still advance to nxt.
  - Not defined: the state always advances to nxt.

## Test plan
- Seed 0, send 0x00003039 then 0xD3DC167E, both valid back-to-back -> match_cnt=2, err_cnt=0, word_idx=2, first_err_vld=0.
- Seed 0, send a full 9-word golden frame whose word 8 has the upper bits set to garbage and the correct low 15 bits -> match_cnt=9, word_idx=0.
- Seed 0, send 0x00003039 then 0xD3DC167F -> err_cnt=1, first_err_idx=1, first_err_exp=0xD3DC167E, first_err_got=0xD3DC167F. A third correct word gives match_cnt=2 without the macro. With LCG_CHK_RESYNC_EN, the third word matches only if it is derived from 0xD3DC167F.
- Random in_valid gaps over 3 frames of golden data -> match_cnt=27, err_cnt=0, and no state advance on cycles with in_valid=0.
- Assert seed_valid mid-frame alongside in_valid -> the word is dropped, counters are cleared, and word_idx=0 on the next cycle. Assert rst mid-frame -> in_ready=0 and all outputs are 0.
- CNT_W=4, 20 golden words -> match_cnt holds at 15.
